// File: rtl/prm_edge_mask_accum_if.sv
// -----------------------------------------------------------------------------
// prm_edge_mask_accum_if
//
// Groups every non-clock signal of prm_edge_mask_accum into one bundle.
//
// Handshake semantics (both channels, vox_* and blk_*):
//   A transfer happens on a rising clk edge when valid and ready are both 1.
//   The source holds valid and its payload stable until that edge. The sink
//   may drive ready independently of valid. Payload is don't-care while valid
//   is 0.
//
// Signal summary:
//   vox_valid / vox_ready / vox_idx / vox_last : voxel input stream
//   chk_idx   : registered voxel index fanned out to the checker bank
//   chk_mask  : combinational per-edge checker results for chk_idx
//   blk_valid / blk_ready : result handshake toward roadmap pruning
//   blk_mask  : blocked-edge bitmap, blk_count : popcount of blk_mask
//   vox_count : voxels accepted this frame (saturating)
//
// Modports:
//   master : environment side (voxel source, checker bank, result sink)
//   slave  : the accumulator block itself
// -----------------------------------------------------------------------------
interface prm_edge_mask_accum_if #(
    parameter int NUM_EDGES = 512,
    parameter int VOX_W     = 15,
    parameter int CNT_W     = 16
);
    logic                 vox_valid;
    logic                 vox_ready;
    logic [VOX_W-1:0]     vox_idx;
    logic                 vox_last;

    logic [VOX_W-1:0]     chk_idx;
    logic [NUM_EDGES-1:0] chk_mask;

    logic                 blk_valid;
    logic                 blk_ready;
    logic [NUM_EDGES-1:0] blk_mask;
    logic [CNT_W-1:0]     blk_count;
    logic [CNT_W-1:0]     vox_count;

    modport master (
        output vox_valid,
        output vox_idx,
        output vox_last,
        output chk_mask,
        output blk_ready,
        input  vox_ready,
        input  chk_idx,
        input  blk_valid,
        input  blk_mask,
        input  blk_count,
        input  vox_count
    );

    modport slave (
        input  vox_valid,
        input  vox_idx,
        input  vox_last,
        input  chk_mask,
        input  blk_ready,
        output vox_ready,
        output chk_idx,
        output blk_valid,
        output blk_mask,
        output blk_count,
        output vox_count
    );
endinterface

// File: rtl/prm_edge_mask_accum.sv
// -----------------------------------------------------------------------------
// prm_edge_mask_accum
//
// Accepts a frame of obstacle voxel indices, presents each index (registered)
// to the per-edge checker bank, and ORs the returned edge mask into a
// blocked-edge bitmap. After the last voxel the pipeline drains, the bitmap is
// popcounted 16 bits per cycle, and bitmap plus count are offered downstream.
//
// Ports:
//   clk        : sole clock, rising edge
//   rst        : synchronous, active-high reset
//   bus        : prm_edge_mask_accum_if.slave (voxel stream, checker bank
//                index/mask, result handshake, counters)
//   dbg_state  : current FSM state (0 ACC, 1 DRAIN, 2 COUNT, 3 OUT)
//
// Timing (last voxel accepted at edge t):
//   edge t+1        : checker mask of last voxel ORed into the bitmap
//   edges t+1..t+3  : DRAIN, leaves once both pipeline flags are clear
//   edges t+4..     : one 16-bit slice counted per edge
//   after t+3+NUM_EDGES/16 : blk_valid high until the result handshake
// -----------------------------------------------------------------------------
module prm_edge_mask_accum #(
    parameter int NUM_EDGES = 512,
    parameter int VOX_W     = 15,
    parameter int CNT_W     = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    prm_edge_mask_accum_if.slave        bus,
    output logic [1:0]                  dbg_state
);

    localparam int NUM_SLICES = NUM_EDGES / 16;
    localparam int SLICE_W    = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

    // Build-time parameter sanity: the counting datapath works on whole
    // 16-bit slices, and the count register must be able to hold NUM_EDGES.
    if ((NUM_EDGES % 16) != 0 || NUM_EDGES < 16) begin : g_bad_num_edges
        $error("prm_edge_mask_accum: NUM_EDGES must be a positive multiple of 16");
    end
    if ($clog2(NUM_EDGES + 1) > CNT_W) begin : g_bad_cnt_w
        $error("prm_edge_mask_accum: CNT_W too narrow to hold NUM_EDGES");
    end

    typedef enum logic [1:0] {
        ST_ACC   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_COUNT = 2'd2,
        ST_OUT   = 2'd3
    } state_e;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e               state_q,   state_d;
    logic [VOX_W-1:0]     chk_idx_q, chk_idx_d;
    logic                 s1_vld_q,  s1_vld_d;
    logic                 s2_vld_q,  s2_vld_d;
    logic [NUM_EDGES-1:0] acc_q,     acc_d;
    logic [CNT_W-1:0]     cnt_q,     cnt_d;
    logic [CNT_W-1:0]     vox_cnt_q, vox_cnt_d;
    logic [SLICE_W-1:0]   slice_q,   slice_d;

    logic                 accept;
    logic                 last_slice;
    logic [15:0]          slice_bits;
    logic [4:0]           slice_pop;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'd0, v[i]};
        end
        return n;
    endfunction

    // -------------------------------------------------------------------------
    // Slice selection for the counting phase
    // -------------------------------------------------------------------------
    always_comb begin
        slice_bits = '0;
        for (int i = 0; i < NUM_SLICES; i++) begin
            if (slice_q == SLICE_W'(i)) begin
                slice_bits = acc_q[i*16 +: 16];
            end
        end
    end

    assign slice_pop  = popcount16(slice_bits);
    assign last_slice = (slice_q == SLICE_W'(NUM_SLICES - 1));
    assign accept     = bus.vox_valid && (state_q == ST_ACC);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        chk_idx_d = chk_idx_q;
        s1_vld_d  = accept;
        s2_vld_d  = s1_vld_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        vox_cnt_d = vox_cnt_q;
        slice_d   = slice_q;

        // Stage 1: register the index that the checker bank evaluates.
        if (accept) begin
            chk_idx_d = bus.vox_idx;
            if (vox_cnt_q != {CNT_W{1'b1}}) begin
                vox_cnt_d = vox_cnt_q + CNT_W'(1);
            end
        end

        // Stage 2: chk_mask has had a full cycle to settle from chk_idx_q.
        if (s1_vld_q) begin
            acc_d = acc_q | bus.chk_mask;
        end

        case (state_q)
            ST_ACC: begin
                if (accept && bus.vox_last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Wait for the last voxel's mask to land in the bitmap.
                if (!s1_vld_q && !s2_vld_q) begin
                    state_d = ST_COUNT;
                    slice_d = '0;
                end
            end
            ST_COUNT: begin
                cnt_d   = cnt_q + CNT_W'(slice_pop);
                slice_d = slice_q + SLICE_W'(1);
                if (last_slice) begin
                    state_d = ST_OUT;
                    slice_d = '0;
                end
            end
            ST_OUT: begin
                if (bus.blk_ready) begin
                    acc_d     = '0;
                    cnt_d     = '0;
                    vox_cnt_d = '0;
                    state_d   = ST_ACC;
                end
            end
            default: begin
                state_d = ST_ACC;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_ACC;
            chk_idx_q <= '0;
            s1_vld_q  <= 1'b0;
            s2_vld_q  <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
            vox_cnt_q <= '0;
            slice_q   <= '0;
        end else begin
            state_q   <= state_d;
            chk_idx_q <= chk_idx_d;
            s1_vld_q  <= s1_vld_d;
            s2_vld_q  <= s2_vld_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            vox_cnt_q <= vox_cnt_d;
            slice_q   <= slice_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // Bitmap and count are only presented while the result is offered, so a
    // partially built frame never shows up on the result bus.
    assign bus.vox_ready = (state_q == ST_ACC);
    assign bus.chk_idx   = chk_idx_q;
    assign bus.blk_valid = (state_q == ST_OUT);
    assign bus.blk_mask  = (state_q == ST_OUT) ? acc_q : '0;
    assign bus.blk_count = (state_q == ST_OUT) ? cnt_q : '0;
    assign bus.vox_count = vox_cnt_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_prm_edge_mask_accum.sv
// -----------------------------------------------------------------------------
// tb_prm_edge_mask_accum
//
// Bench for prm_edge_mask_accum with a 32-edge checker bank model:
// chk_mask = 1 << (chk_idx % 32), or all-ones for index 5 when all_ones_mode.
// Frame results expected by the model are queued when the last voxel is
// accepted and compared when the DUT completes its result handshake.
// -----------------------------------------------------------------------------
module tb_prm_edge_mask_accum;

    localparam int NE = 32;
    localparam int VW = 15;
    localparam int CW = 16;
    localparam int LATENCY = 3 + NE / 16;

    // -------------------------------------------------------------------------
    // Clock / reset
    // -------------------------------------------------------------------------
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    prm_edge_mask_accum_if #(.NUM_EDGES(NE), .VOX_W(VW), .CNT_W(CW)) bus ();

    prm_edge_mask_accum #(
        .NUM_EDGES (NE),
        .VOX_W     (VW),
        .CNT_W     (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // -------------------------------------------------------------------------
    // Checker bank model
    // -------------------------------------------------------------------------
    bit all_ones_mode = 1'b0;

    function automatic logic [NE-1:0] model_mask(input logic [VW-1:0] idx, input bit ones);
        logic [NE-1:0] m;
        if (ones && idx == VW'(5)) begin
            m = '1;
        end else begin
            m = '0;
            m[idx[4:0]] = 1'b1;
        end
        return m;
    endfunction

    always_comb bus.chk_mask = model_mask(bus.chk_idx, all_ones_mode);

    // -------------------------------------------------------------------------
    // Scoreboard state
    // -------------------------------------------------------------------------
    int             checks   = 0;
    int             failures = 0;
    longint         cyc      = 0;
    longint         last_acc_cyc = 0;
    logic [NE-1:0]  exp_mask_q[$];
    logic [CW-1:0]  exp_cnt_q[$];
    logic [CW-1:0]  exp_vc_q[$];
    logic [NE-1:0]  model_acc = '0;
    logic [CW-1:0]  model_vc  = '0;
    bit             prev_blk_valid = 1'b0;
    int             spam_accepts = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CW-1:0] popcount(input logic [NE-1:0] v);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < NE; i++) n = n + CW'(v[i]);
        return n;
    endfunction

    // Result monitor: latency on rising blk_valid, payload on handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.blk_valid && !prev_blk_valid) begin
                check_val("latency", 64'(cyc - last_acc_cyc), 64'(LATENCY));
            end
            if (bus.blk_valid && bus.blk_ready) begin
                if (exp_mask_q.size() == 0) begin
                    check_val("unexpected_result", 64'd1, 64'd0);
                end else begin
                    check_val("blk_mask",  64'(bus.blk_mask),  64'(exp_mask_q.pop_front()));
                    check_val("blk_count", 64'(bus.blk_count), 64'(exp_cnt_q.pop_front()));
                    check_val("vox_count", 64'(bus.vox_count), 64'(exp_vc_q.pop_front()));
                end
            end
        end
        prev_blk_valid = bus.blk_valid;
    end

    // -------------------------------------------------------------------------
    // Driver tasks
    // -------------------------------------------------------------------------
    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send_voxel(input int idx, input bit last, input int gap);
        bit accepted;
        bus.vox_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        bus.vox_valid = 1'b1;
        bus.vox_idx   = VW'(idx);
        bus.vox_last  = last;
        accepted = 1'b0;
        for (int k = 0; k < 200 && !accepted; k++) begin
            @(negedge clk);
            accepted = bus.vox_ready;
            @(posedge clk);
            #1;
        end
        bus.vox_valid = 1'b0;
        bus.vox_last  = 1'b0;
        if (!accepted) begin
            check_val("accept_timeout", 64'd0, 64'd1);
        end else begin
            last_acc_cyc = cyc;
            model_acc = model_acc | model_mask(VW'(idx), all_ones_mode);
            if (model_vc != '1) model_vc = model_vc + CW'(1);
            if (last) begin
                exp_mask_q.push_back(model_acc);
                exp_cnt_q.push_back(popcount(model_acc));
                exp_vc_q.push_back(model_vc);
                model_acc = '0;
                model_vc  = '0;
            end
        end
    endtask

    // Waits for blk_valid (blk_ready assumed 1), then steps past the handshake.
    task automatic wait_result(input bit drop_spam);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (bus.vox_valid && bus.vox_ready) spam_accepts++;
            if (bus.blk_valid) seen = 1'b1;
        end
        if (drop_spam) bus.vox_valid = 1'b0;
        if (!seen) check_val("result_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        check_val({tag, "_vox_ready"}, 64'(bus.vox_ready), 64'd1);
        check_val({tag, "_blk_valid"}, 64'(bus.blk_valid), 64'd0);
        check_val({tag, "_blk_mask"},  64'(bus.blk_mask),  64'd0);
        check_val({tag, "_blk_count"}, 64'(bus.blk_count), 64'd0);
        check_val({tag, "_vox_count"}, 64'(bus.vox_count), 64'd0);
        check_val({tag, "_chk_idx"},   64'(bus.chk_idx),   64'd0);
        check_val({tag, "_state"},     64'(dbg_state),     64'd0);
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        int bad;
        rst           = 1'b1;
        bus.vox_valid = 1'b0;
        bus.vox_idx   = '0;
        bus.vox_last  = 1'b0;
        bus.blk_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;

        // Frame {3,7,3,40}: bits 3,7,8 -> 0x188, count 3, vox_count 4.
        send_voxel(3, 1'b0, 0);
        send_voxel(7, 1'b0, 0);
        send_voxel(3, 1'b0, 0);
        send_voxel(40, 1'b1, 0);
        wait_result(1'b0);

        // Single-voxel frame.
        send_voxel(0, 1'b1, 0);
        wait_result(1'b0);

        // All-ones mask for index 5, result held with blk_ready low.
        all_ones_mode = 1'b1;
        bus.blk_ready = 1'b0;
        send_voxel(5, 1'b1, 0);
        bad = 1;
        for (int k = 0; k < 200 && bad != 0; k++) begin
            @(negedge clk);
            if (bus.blk_valid) bad = 0;
        end
        check_val("hold_valid_seen", 64'(bad), 64'd0);
        bad = 0;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.blk_mask != '1 || bus.blk_count != CW'(32) || bus.vox_ready || !bus.blk_valid)
                bad++;
        end
        check_val("hold_stable_bad_cycles", 64'(bad), 64'd0);
        @(posedge clk);
        #1;
        bus.blk_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_val("post_hs_vox_ready", 64'(bus.vox_ready), 64'd1);
        check_val("post_hs_blk_valid", 64'(bus.blk_valid), 64'd0);
        check_val("post_hs_vox_count", 64'(bus.vox_count), 64'd0);
        @(posedge clk);
        #1;
        send_voxel(1, 1'b1, 0);
        wait_result(1'b0);
        all_ones_mode = 1'b0;

        // vox_valid kept high through DRAIN/COUNT/OUT must not be accepted.
        send_voxel(9, 1'b0, 0);
        send_voxel(10, 1'b1, 0);
        bus.vox_valid = 1'b1;
        bus.vox_idx   = VW'(20);
        bus.vox_last  = 1'b1;
        spam_accepts  = 0;
        wait_result(1'b1);
        check_val("spam_accepts", 64'(spam_accepts), 64'd0);

        // Reset in the middle of a frame discards it.
        send_voxel(1, 1'b0, 0);
        send_voxel(2, 1'b0, 0);
        send_voxel(3, 1'b0, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_acc = '0;
        model_vc  = '0;
        check_reset_outputs("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.blk_valid) bad++;
        end
        check_val("midrst_no_valid", 64'(bad), 64'd0);
        @(posedge clk);
        #1;
        send_voxel(4, 1'b1, 0);
        wait_result(1'b0);

        // Saturation: 66000 voxels cycling 0..31, the first 600 gapped.
        for (int i = 0; i < 66000; i++) begin
            send_voxel(i % 32, (i == 65999), (i < 600) ? 2 : 0);
        end
        wait_result(1'b0);

        repeat (5) @(posedge clk);
        @(negedge clk);
        check_val("queue_empty", 64'(exp_mask_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
